iir_biquad_mc: RTL
==================

IIR_BIQUAD_MC -- requirements
Module: iir_biquad_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter COEF_W, default 18: coefficient width, signed.
REQ-003 SHALL have parameter FRAC_W, default 16: coefficient fractional bits, so 1.0 = 2^FRAC_W.
REQ-004 SHALL have parameter CHANNELS, default 2: number of independent filter channels, at least 1.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port clear_i, input, 1: synchronous clear of all channel histories.
REQ-008 SHALL have ports b0_i, b1_i, b2_i, a1_i, a2_i, input, COEF_W each: signed coefficients.
REQ-009 SHALL have port in_valid_i, input, 1: input sample valid.
REQ-010 SHALL have port in_ready_o, output, 1: block can accept a sample.
REQ-011 SHALL have port in_ch_i, input, clog2(CHANNELS) (min 1): channel of the input sample.
REQ-012 SHALL have port data_i, input, DATA_W: signed input sample.
REQ-013 SHALL have port out_valid_o, output, 1: one-cycle pulse marking a result.
REQ-014 SHALL have port out_ch_o, output, same width as in_ch_i: channel of the result.
REQ-015 SHALL have port data_o, output, DATA_W: signed filtered sample.
REQ-016 SHALL have port sat_o, output, 1: result was clipped; valid with out_valid_o.
REQ-017 SHALL have port err_o, output, 1: sticky flag for an out-of-range channel.

Function
REQ-018 SHALL implement direct form I: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, with separate x1, x2, y1, y2 history per channel.
REQ-019 SHALL accumulate at ACC_W = DATA_W+COEF_W+3 bits with no intermediate truncation.
REQ-020 SHALL form the result as (acc + 2^(FRAC_W-1)) arithmetically shifted right by FRAC_W, then saturated to the DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-021 SHALL set sat_o=1 when saturation alters the value; the saturated value is written to y1.
REQ-022 SHALL use an FSM with states IDLE, MAC and OUT.
REQ-023 SHALL, in IDLE, drive in_ready_o=1 unless clear_i=1.
REQ-024 SHALL transfer a sample on in_valid_i && in_ready_o; data_i, in_ch_i and all five coefficients latched at that edge.
REQ-025 SHALL move IDLE->MAC at transfer, using one multiplier for one product per cycle, 5 cycles in order b0, b1, b2, a1, a2.
REQ-026 SHALL move MAC->OUT, then OUT->IDLE after one cycle.
REQ-027 SHALL drive in_ready_o=0 in MAC and OUT.
REQ-028 SHALL register data_o, out_ch_o and sat_o and pulse out_valid_o for exactly one cycle, 6 cycles after the transfer edge (throughput one sample per 7 cycles).
REQ-029 SHALL, on the OUT edge for the channel: x2<=x1, x1<=x, y2<=y1, y1<=result; other channels unchanged.
REQ-030 SHALL hold data_o, out_ch_o and sat_o between pulses.
REQ-031 SHALL, for a sample with in_ch_i >= CHANNELS: accept it, produce no out_valid_o, alter no history, set err_o=1 until reset, and return to IDLE.
REQ-032 SHALL, on clear_i=1: zero all histories at that edge, abort any MAC/OUT operation with no out_valid_o, return to IDLE, and accept no sample; clear has priority over a simultaneous in_valid_i.
REQ-033 SHALL ignore coefficient changes after transfer until the next transfer.

Reset
REQ-034 SHALL, while reset_i=1, immediately and asynchronously set: FSM=IDLE; all histories 0; data_o=0; out_ch_o=0; out_valid_o=0; sat_o=0; err_o=0; in_ready_o=0.
REQ-035 SHALL drive in_ready_o=1 in the first cycle after reset_i deasserts.
REQ-036 SHALL, on reset mid-operation, discard the sample with no out_valid_o.

Verification (defaults DATA_W=16, COEF_W=18, FRAC_W=16, CHANNELS=2)
REQ-037 SHALL cover pass-through: b0=65536, others 0, x=1234 on ch0 -> data_o=1234, out_ch_o=0, out_valid_o exactly 6 cycles after the transfer.
REQ-038 SHALL cover FIR impulse: b0=b1=b2=16384, a=0, x=4000,0,0,0 -> 1000,1000,1000,0.
REQ-039 SHALL cover feedback: b0=65536, a1=-65536, x=100 three times -> 100,200,300.
REQ-040 SHALL cover saturation: b0=131071, x=30000 -> 32767 with sat_o=1; x=-30000 -> -32768 with sat_o=1.
REQ-041 SHALL cover channel isolation and clear: ch0/ch1 interleaved per REQ-039 -> each channel counts 100,200,300 independently; clear_i then x=100 -> 100.
REQ-042 SHALL cover out-of-range and reset: in_ch_i=1 with CHANNELS=1 -> no out_valid_o, err_o=1; reset_i in MAC -> no out_valid_o, all outputs 0.

Source files
------------

// File: rtl/iir_biquad_mc.sv
// Multi-channel direct-form-I biquad IIR filter sharing one multiplier.
// One sample per 7 cycles: transfer, 5 MAC cycles (b0,b1,b2,a1,a2), output.
module iir_biquad_mc #(
  parameter  int DATA_W   = 16,
  parameter  int COEF_W   = 18,
  parameter  int FRAC_W   = 16,
  parameter  int CHANNELS = 2,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic signed [COEF_W-1:0] b0_i,
  input  logic signed [COEF_W-1:0] b1_i,
  input  logic signed [COEF_W-1:0] b2_i,
  input  logic signed [COEF_W-1:0] a1_i,
  input  logic signed [COEF_W-1:0] a2_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [CH_W-1:0]          in_ch_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic                     out_valid_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     sat_o,
  output logic                     err_o
);

  localparam int ACC_W = DATA_W + COEF_W + 3;
  localparam int PW    = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, next;
  logic [2:0] cnt;
  logic [CH_W-1:0] ch_q;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [COEF_W-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [DATA_W-1:0] x1 [CHANNELS];
  logic signed [DATA_W-1:0] x2 [CHANNELS];
  logic signed [DATA_W-1:0] y1 [CHANNELS];
  logic signed [DATA_W-1:0] y2 [CHANNELS];
  logic signed [ACC_W-1:0]  acc;

  logic transfer, ch_ok;
  assign transfer = in_valid_i && in_ready_o;
  assign ch_ok    = 32'(in_ch_i) < CHANNELS;

  always_comb begin
    next       = state;
    in_ready_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = !clear_i && !reset_i;
        if (transfer && ch_ok) next = MAC;
      end
      MAC:     if (cnt == 3'd4) next = OUT;
      OUT:     next = IDLE;
      default: next = IDLE;
    endcase
    if (clear_i) next = IDLE;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next;
  end

  // Shared multiplier: operand pair selected by the MAC step; feedback terms subtract.
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [DATA_W-1:0] data_sel;
  logic                     sub;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext, term;

  always_comb begin
    coef_sel = b0_q;
    data_sel = x_cur;
    sub      = 1'b0;
    case (cnt)
      3'd1: begin coef_sel = b1_q; data_sel = x1[ch_q]; end
      3'd2: begin coef_sel = b2_q; data_sel = x2[ch_q]; end
      3'd3: begin coef_sel = a1_q; data_sel = y1[ch_q]; sub = 1'b1; end
      3'd4: begin coef_sel = a2_q; data_sel = y2[ch_q]; sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = PW'(coef_sel) * PW'(data_sel);
  assign prod_ext = ACC_W'(prod);
  assign term     = sub ? -prod_ext : prod_ext;

  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] result;
  logic                     clipped;

  always_comb begin
    shifted = (acc + RND) >>> FRAC_W;
    result  = shifted[DATA_W-1:0];
    clipped = 1'b0;
    if (shifted > Y_MAX) begin
      result  = Y_MAX[DATA_W-1:0];
      clipped = 1'b1;
    end else if (shifted < Y_MIN) begin
      result  = Y_MIN[DATA_W-1:0];
      clipped = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt         <= '0;
      ch_q        <= '0;
      x_cur       <= '0;
      acc         <= '0;
      {b0_q, b1_q, b2_q, a1_q, a2_q} <= '0;
      out_valid_o <= 1'b0;
      out_ch_o    <= '0;
      data_o      <= '0;
      sat_o       <= 1'b0;
      err_o       <= 1'b0;
      // NOTE: history is a handful of flops, not RAM, so it can take the async reset.
      for (int c = 0; c < CHANNELS; c++) begin
        x1[c] <= '0; x2[c] <= '0; y1[c] <= '0; y2[c] <= '0;
      end
    end else begin
      out_valid_o <= 1'b0;
      if (clear_i) begin
        for (int c = 0; c < CHANNELS; c++) begin
          x1[c] <= '0; x2[c] <= '0; y1[c] <= '0; y2[c] <= '0;
        end
      end else begin
        case (state)
          IDLE: if (transfer) begin
            if (ch_ok) begin
              ch_q  <= in_ch_i;
              x_cur <= data_i;
              b0_q  <= b0_i; b1_q <= b1_i; b2_q <= b2_i;
              a1_q  <= a1_i; a2_q <= a2_i;
              acc   <= '0;
              cnt   <= '0;
            end else begin
              err_o <= 1'b1;
            end
          end
          MAC: begin
            acc <= acc + term;
            cnt <= cnt + 3'd1;
          end
          OUT: begin
            data_o      <= result;
            sat_o       <= clipped;
            out_ch_o    <= ch_q;
            out_valid_o <= 1'b1;
            x2[ch_q]    <= x1[ch_q];
            x1[ch_q]    <= x_cur;
            y2[ch_q]    <= y1[ch_q];
            y1[ch_q]    <= result;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
